// File: rtl/dc_motor_pkg.sv
// Shared constants for the DC motor PWM driver: PWM period length and
// the widths of the duty and phase-counter registers.
package dc_motor_pkg;

  localparam int PWM_STEPS = 7;
  localparam int DUTY_W    = 3;
  localparam int CNT_W     = 3;

  // Last phase value before the counter wraps back to zero.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_STEPS - 1);

endpackage

// File: rtl/dc_motor_sync_2ff.sv
// Two-flop synchronizer that brings the asynchronous speed switch into
// the clk domain; both flops clear on reset.
module sync_2ff #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dc_motor.sv
// Seven-step PWM generator for a DC motor driver. The synchronized speed
// switch is latched only at period boundaries so a period is never cut short.
module dc_motor
  import dc_motor_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] psw,
  output logic       pdcm
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic [DUTY_W-1:0] psw_s;
  logic [15:0]       presc;
  logic              tick;
  logic [CNT_W-1:0]  cnt;
  logic              wrap;
  logic [DUTY_W-1:0] duty_q;

  sync_2ff #(
    .WIDTH(DUTY_W)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (psw),
    .q     (psw_s)
  );

  // With PRESCALE=1 the prescaler sits at zero and tick is always high.
  assign tick = (presc == PS_LAST);
  assign wrap = tick && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

  // New duty takes effect only on the 6->0 wrap, so periods stay whole.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
    end else if (wrap) begin
      duty_q <= psw_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pdcm <= 1'b0;
    end else begin
      pdcm <= (cnt < duty_q);
    end
  end

endmodule

// File: tb/tb_dc_motor.sv
// Bench for dc_motor: two instances (PRESCALE 1 and 4) checked against an
// arithmetic model of the PWM period and the boundary-latched duty.
module tb_dc_motor;

  localparam int MAXK = 8192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] psw_a = 3'd0;
  logic [2:0] psw_b = 3'd0;
  logic       pdcm_a;
  logic       pdcm_b;

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;

  int   hist_a [0:MAXK];
  int   hist_b [0:MAXK];
  logic out_a  [0:MAXK];

  always #5 clk = ~clk;

  dc_motor #(.PRESCALE(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .psw   (psw_a),
    .pdcm  (pdcm_a)
  );

  dc_motor #(.PRESCALE(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .psw   (psw_b),
    .pdcm  (pdcm_b)
  );

  // One clk: record the switch values seen at the edge, then settle to negedge.
  task automatic step();
    @(posedge clk);
    if (rst_n && k < MAXK) begin
      k = k + 1;
      hist_a[k] = psw_a;
      hist_b[k] = psw_b;
    end
    @(negedge clk);
    if (rst_n && k < MAXK) out_a[k] = pdcm_a;
  endtask

  // Duty in force before edge kk: the switch value seen two edges ahead of
  // the latest period boundary (multiple of 7*p edges) strictly before kk.
  function automatic int exp_duty(int kk, int p, bit use_b);
    int b;
    if (kk < 1) return 0;
    b = ((kk - 1) / (7 * p)) * (7 * p);
    if (b == 0) return 0;
    return use_b ? hist_b[b - 2] : hist_a[b - 2];
  endfunction

  function automatic logic exp_pdcm(int kk, int p, bit use_b);
    if (kk < 1) return 1'b0;
    return ((((kk - 1) / p) % 7) < exp_duty(kk, p, use_b)) ? 1'b1 : 1'b0;
  endfunction

  function automatic int high_count(int first, int last);
    int s = 0;
    for (int i = first; i <= last; i++) s += (out_a[i] === 1'b1) ? 1 : 0;
    return s;
  endfunction

  task automatic test_reset();
    logic e;
    rst_n = 1'b0;
    psw_a = 3'd7;
    psw_b = 3'd3;
    k = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (pdcm_a !== 1'b0 || pdcm_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pdcm_a=%b pdcm_b=%b required 0 0", pdcm_a, pdcm_b);
    end
    rst_n = 1'b1;
    repeat (20) step();
    e = exp_pdcm(k, 1, 1'b0);
    n_tests++;
    if (pdcm_a !== e) begin
      n_fail++;
      $display("FAIL pre_reset_drive: pdcm_a=%b required %b", pdcm_a, e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (pdcm_a !== 1'b0 || pdcm_b !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: pdcm_a=%b pdcm_b=%b required 0 0", pdcm_a, pdcm_b);
    end
    k = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      n_tests++;
      if (pdcm_a !== 1'b0) begin
        n_fail++;
        $display("FAIL first_period_zero: cycle %0d pdcm_a=%b required 0", i, pdcm_a);
      end
    end
  endtask

  task automatic test_duty_sweep();
    logic e;
    int hc;
    for (int v = 0; v < 8; v++) begin
      psw_a = 3'(v);
      for (int i = 0; i < 40; i++) begin
        step();
        e = exp_pdcm(k, 1, 1'b0);
        n_tests++;
        if (pdcm_a !== e) begin
          n_fail++;
          $display("FAIL sweep_model: psw=%0d k=%0d pdcm_a=%b required %b", v, k, pdcm_a, e);
        end
      end
      hc = high_count(k - 6, k);
      n_tests++;
      if (hc != v) begin
        n_fail++;
        $display("FAIL sweep_window: psw=%0d high=%0d required %0d", v, hc, v);
      end
    end
  endtask

  task automatic test_boundary_latch();
    int k0;
    int h1;
    int h2;
    psw_a = 3'd3;
    repeat (20) step();
    for (int i = 0; i < 7 && (k % 7) != 2; i++) step();
    k0 = k;
    psw_a = 3'd5;
    while (k < k0 + 12) step();
    h1 = high_count(k0 - 1, k0 + 5);
    h2 = high_count(k0 + 6, k0 + 12);
    n_tests++;
    if (h1 != 3) begin
      n_fail++;
      $display("FAIL latch_current: high=%0d required 3", h1);
    end
    n_tests++;
    if (h2 != 5) begin
      n_fail++;
      $display("FAIL latch_next: high=%0d required 5", h2);
    end
  endtask

  task automatic test_glitch();
    int k0;
    int hc;
    psw_a = 3'd2;
    repeat (20) step();
    for (int i = 0; i < 7 && (k % 7) != 1; i++) step();
    k0 = k;
    psw_a = 3'd6;
    step();
    step();
    psw_a = 3'd2;
    repeat (21) step();
    for (int j = 0; j < 3; j++) begin
      hc = high_count(k0 + 7 * j, k0 + 7 * j + 6);
      n_tests++;
      if (hc != 2) begin
        n_fail++;
        $display("FAIL glitch_window%0d: high=%0d required 2", j, hc);
      end
    end
  endtask

  task automatic test_extremes();
    for (int v = 0; v < 2; v++) begin
      logic want;
      want = (v == 1);
      psw_a = (v == 1) ? 3'd7 : 3'd0;
      repeat (15) step();
      for (int i = 0; i < 21; i++) begin
        step();
        n_tests++;
        if (pdcm_a !== want) begin
          n_fail++;
          $display("FAIL extreme_psw%0d: cycle %0d pdcm_a=%b required %b", psw_a, i, pdcm_a, want);
        end
      end
    end
  endtask

  task automatic test_prescale();
    logic prev;
    int hi;
    int lo;
    bit found;
    psw_b = 3'd3;
    repeat (70) step();
    found = 1'b0;
    prev = pdcm_b;
    for (int i = 0; i < 64 && !found; i++) begin
      step();
      if (prev === 1'b0 && pdcm_b === 1'b1) found = 1'b1;
      prev = pdcm_b;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL prescale_rise: no rising edge within 64 clk");
    end else begin
      for (int r = 0; r < 2; r++) begin
        hi = 1;
        lo = 0;
        for (int i = 0; i < 40; i++) begin
          step();
          if (pdcm_b !== 1'b1) break;
          hi++;
        end
        if (pdcm_b === 1'b0) lo = 1;
        for (int i = 0; i < 40 && lo > 0; i++) begin
          step();
          if (pdcm_b !== 1'b0) break;
          lo++;
        end
        n_tests++;
        if (hi != 12 || lo != 16) begin
          n_fail++;
          $display("FAIL prescale_run%0d: high=%0d low=%0d required 12 16", r, hi, lo);
        end
      end
    end
  endtask

  task automatic test_random();
    logic ea;
    logic eb;
    int hold;
    for (int s = 0; s < 40; s++) begin
      psw_a = 3'($urandom_range(0, 7));
      psw_b = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 20);
      for (int i = 0; i < hold; i++) begin
        step();
        ea = exp_pdcm(k, 1, 1'b0);
        eb = exp_pdcm(k, 4, 1'b1);
        n_tests++;
        if (pdcm_a !== ea) begin
          n_fail++;
          $display("FAIL random_p1: k=%0d pdcm_a=%b required %b", k, pdcm_a, ea);
        end
        n_tests++;
        if (pdcm_b !== eb) begin
          n_fail++;
          $display("FAIL random_p4: k=%0d pdcm_b=%b required %b", k, pdcm_b, eb);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_duty_sweep();
    test_boundary_latch();
    test_glitch();
    test_extremes();
    test_prescale();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
